// File: rtl/decimal_keypad_ctrl_pkg.sv
// Shared types and helpers for the decimal keypad controller.
package decimal_pkg;

    localparam int NUM_KEYS = 10;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        EMIT,
        RELEASE
    } kp_state_t;

    // True when exactly one of the ten key lines is set.
    function automatic logic is_onehot10(input logic [NUM_KEYS-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            n = n + {3'b000, v[i]};
        end
        return (n == 4'd1);
    endfunction

endpackage

// File: rtl/decimal_keypad_ctrl_if.sv
// Digit delivery handshake between the keypad controller and its consumer.
interface decimal_keypad_ctrl_if;
    import decimal_pkg::*;

    bcd_t digit_out;
    logic digit_valid;
    logic digit_ready;

    modport master (output digit_out, output digit_valid, input digit_ready);
    modport slave  (input digit_out, input digit_valid, output digit_ready);
endinterface

// File: rtl/decimal_keypad_ctrl_encode.sv
// One-hot key vector to BCD digit; valid only when exactly one key is set.
module dec_onehot_encode
    import decimal_pkg::*;
(
    input  logic [NUM_KEYS-1:0] onehot,
    output bcd_t                digit,
    output logic                valid
);

    // Index of the set bit; the value is meaningless when valid is low.
    always_comb begin
        digit = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (onehot[i]) digit = 4'(i);
        end
        valid = is_onehot10(onehot);
    end

endmodule

// File: rtl/decimal_keypad_ctrl.sv
// Debounced single-key decimal keypad controller with chord rejection and
// a valid/ready digit output.
module decimal_keypad_ctrl
    import decimal_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_KEYS-1:0]   key_in,
    decimal_keypad_ctrl_if.master dig,
    output logic                  chord_err,
    output logic                  busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] key_m, key_s;
    logic [NUM_KEYS-1:0] cap, cap_n;
    logic [CW-1:0]       cnt, cnt_n;
    kp_state_t           state, state_n;
    bcd_t                digit_q, digit_n;
    logic                valid_q;
    logic                chord_n;
    bcd_t                enc_digit;
    logic                enc_valid;

    dec_onehot_encode u_enc (
        .onehot (cap),
        .digit  (enc_digit),
        .valid  (enc_valid)
    );

    // Two-flop synchroniser for the asynchronous key lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_m <= '0;
            key_s <= '0;
        end else begin
            key_m <= key_in;
            key_s <= key_m;
        end
    end

    // Next-state, capture, counter and output decisions.
    always_comb begin
        state_n = state;
        cap_n   = cap;
        cnt_n   = cnt;
        digit_n = digit_q;
        chord_n = 1'b0;
        case (state)
            IDLE: begin
                if (key_s != '0) begin
                    cap_n   = key_s;
                    cnt_n   = '0;
                    state_n = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (key_s == '0) begin
                    state_n = IDLE;
                end else if (key_s != cap) begin
                    cap_n = key_s;
                    cnt_n = '0;
                end else if (cnt == CNT_LAST) begin
                    if (enc_valid) begin
                        digit_n = enc_digit;
                        state_n = EMIT;
                    end else begin
                        chord_n = 1'b1;
                        state_n = RELEASE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            EMIT: begin
                // Keys are ignored here; only the handshake moves us on.
                if (valid_q && dig.digit_ready) begin
                    cnt_n   = '0;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (key_s != '0) begin
                    cnt_n = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; outputs follow the next state so they
    // change on the same edge as the transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cap       <= '0;
            cnt       <= '0;
            digit_q   <= '0;
            valid_q   <= 1'b0;
            chord_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cap       <= cap_n;
            cnt       <= cnt_n;
            digit_q   <= digit_n;
            valid_q   <= (state_n == EMIT);
            chord_err <= chord_n;
            busy      <= (state_n != IDLE);
        end
    end

    assign dig.digit_out   = digit_q;
    assign dig.digit_valid = valid_q;

endmodule

// File: tb/tb_decimal_keypad_ctrl.sv
// Scoreboard bench: expected digits (15 = chord error) are queued as keys are
// driven and popped when a DUT delivers a digit or flags a chord.
module tb_decimal_keypad_ctrl;
    import decimal_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NUM_KEYS-1:0] key4 = '0;
    logic [NUM_KEYS-1:0] key2 = '0;
    logic chord4, busy4, chord2, busy2;

    int n_cmp = 0;
    int n_err = 0;
    int q4[$];
    int q2[$];

    decimal_keypad_ctrl_if kif4 ();
    decimal_keypad_ctrl_if kif2 ();

    assign kif2.digit_ready = 1'b1;

    decimal_keypad_ctrl #(.DEBOUNCE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .key_in(key4), .dig(kif4),
        .chord_err(chord4), .busy(busy4)
    );

    decimal_keypad_ctrl #(.DEBOUNCE_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .key_in(key2), .dig(kif2),
        .chord_err(chord2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int lim);
        int n = 0;
        while (!kif4.digit_valid && n < lim) begin
            tick();
            n++;
        end
        chk("wait_valid", int'(kif4.digit_valid), 1);
    endtask

    // Output monitor for the DEBOUNCE_CYCLES=4 instance.
    always @(negedge clk) begin
        if (!rst && ((kif4.digit_valid && kif4.digit_ready) || chord4)) begin
            int ev;
            ev = chord4 ? 15 : int'(kif4.digit_out);
            if (q4.size() == 0) chk("dut4_unexpected_event", ev, -1);
            else                chk("dut4_event", ev, q4.pop_front());
        end
    end

    // Output monitor for the DEBOUNCE_CYCLES=2 instance.
    always @(negedge clk) begin
        if (!rst && ((kif2.digit_valid && kif2.digit_ready) || chord2)) begin
            int ev;
            ev = chord2 ? 15 : int'(kif2.digit_out);
            chk("dut2_range", int'(ev <= 9), 1);
            if (q2.size() == 0) chk("dut2_unexpected_event", ev, -1);
            else                chk("dut2_event", ev, q2.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d pending", q4.size());
        $fatal(1, "watchdog");
    end

    initial begin
        kif4.digit_ready = 1'b1;
        repeat (3) tick();
        chk("rst_digit_out", int'(kif4.digit_out), 0);
        chk("rst_valid", int'(kif4.digit_valid), 0);
        chk("rst_chord", int'(chord4), 0);
        chk("rst_busy", int'(busy4), 0);
        chk("rst_valid2", int'(kif2.digit_valid), 0);
        rst = 1'b0;
        tick();

        // Clean press of key 7: exact latency and release timing.
        key4 = 10'd1 << 7;
        q4.push_back(7);
        repeat (6) tick();
        chk("k7_valid_e6", int'(kif4.digit_valid), 0);
        chk("k7_busy_e6", int'(busy4), 1);
        tick();
        chk("k7_valid_e7", int'(kif4.digit_valid), 1);
        chk("k7_digit", int'(kif4.digit_out), 7);
        tick();
        chk("k7_valid_after_xfer", int'(kif4.digit_valid), 0);
        repeat (12) tick();
        key4 = '0;
        repeat (5) tick();
        chk("k7_busy_hold", int'(busy4), 1);
        tick();
        chk("k7_busy_low", int'(busy4), 0);
        repeat (4) tick();

        // Bouncing key 3 settles to a single digit.
        q4.push_back(3);
        key4 = 10'd1 << 3; repeat (2) tick();
        key4 = '0;         repeat (2) tick();
        key4 = 10'd1 << 3; repeat (20) tick();
        key4 = '0;         repeat (15) tick();

        // Short glitch on key 5: nothing reported.
        key4 = 10'd1 << 5; repeat (3) tick();
        key4 = '0;         repeat (15) tick();
        chk("glitch_idle", int'(busy4), 0);

        // Chord of keys 2 and 9, then a clean key 4.
        q4.push_back(15);
        key4 = (10'd1 << 2) | (10'd1 << 9); repeat (20) tick();
        key4 = '0; repeat (15) tick();
        q4.push_back(4);
        key4 = 10'd1 << 4; repeat (20) tick();
        key4 = '0; repeat (15) tick();

        // Key 0 with back-pressure; release and re-press while waiting.
        kif4.digit_ready = 1'b0;
        q4.push_back(0);
        key4 = 10'd1;
        wait_valid(20);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) key4 = '0;
            if (i == 5) key4 = 10'd1;
            tick();
            chk("hold_valid", int'(kif4.digit_valid), 1);
            chk("hold_digit", int'(kif4.digit_out), 0);
        end
        kif4.digit_ready = 1'b1;
        tick();
        chk("hold_xfer_drop", int'(kif4.digit_valid), 0);
        repeat (5) tick();
        key4 = '0; repeat (15) tick();

        // Reset during EMIT with key 6 held: digit discarded, then re-detected.
        kif4.digit_ready = 1'b0;
        key4 = 10'd1 << 6;
        wait_valid(20);
        rst = 1'b1;
        #1;
        chk("midrst_valid", int'(kif4.digit_valid), 0);
        chk("midrst_digit", int'(kif4.digit_out), 0);
        chk("midrst_busy", int'(busy4), 0);
        tick();
        tick();
        rst = 1'b0;
        q4.push_back(6);
        repeat (6) tick();
        chk("k6_valid_e6", int'(kif4.digit_valid), 0);
        tick();
        chk("k6_valid_e7", int'(kif4.digit_valid), 1);
        chk("k6_digit", int'(kif4.digit_out), 6);
        kif4.digit_ready = 1'b1;
        tick();
        key4 = '0; repeat (15) tick();

        // Sweep all keys on the short-debounce instance.
        for (int k = 0; k < NUM_KEYS; k++) begin
            q2.push_back(k);
            key2 = 10'd1 << k;
            repeat (10) tick();
            key2 = '0;
            repeat (10) tick();
        end

        chk("q4_drained", q4.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decimal_keypad_ctrl.md
# decimal_keypad_ctrl

Scanning controller for a 10-key decimal keypad, with keys 0-9 as one active-high line each. It synchronises and debounces the raw key lines and accepts only single-key presses. Each accepted key is encoded to a 4-bit BCD digit and delivered on a valid/ready handshake to downstream digit logic (display or accumulator). It rejects multi-key chords and waits for full release before accepting the next key.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a press or a release; legal range 2..65535.
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_in  input  10  raw key lines, asynchronous to clk; bit n = key n.
- digit_out  output  4  BCD digit 0-9; valid only while digit_valid=1.
- digit_valid  output  1  digit available; held until accepted.
- digit_ready  input  1  downstream accepts digit when digit_valid & digit_ready.
- chord_err  output  1  one-cycle pulse: stable press had ≠1 key set.
- busy  output  1  high in any state except IDLE.

## Operation
- key_in passes through a 2-flop synchroniser to give key_s[9:0]. Both flops reset to 0.
- A 10-bit capture register `cap` and a debounce counter `cnt` track the press. cnt is $clog2(DEBOUNCE_CYCLES) bits wide and saturates; it never wraps.
- States are IDLE, DEBOUNCE, EMIT and RELEASE. Reset state is IDLE.
- IDLE:
  - if key_s ≠ 0: cap ← key_s, cnt ← 0, go to DEBOUNCE.
- DEBOUNCE:
  - if key_s = 0: go to IDLE (glitch, nothing emitted).
  - else if key_s ≠ cap: cap ← key_s, cnt ← 0, stay.
  - else if cnt = DEBOUNCE_CYCLES-1: if cap is one-hot, digit_out ← index of the set bit and go to EMIT; otherwise pulse chord_err for one cycle and go to RELEASE.
  - else cnt ← cnt+1.
- EMIT:
  - digit_valid=1 and digit_out is held constant.
  - digit_valid does not depend combinationally on digit_ready.
  - On digit_valid & digit_ready: go to RELEASE with cnt ← 0.
  - Key activity during EMIT is ignored. A key that is released and re-pressed before acceptance yields no second digit.
- RELEASE:
  - if key_s ≠ 0: cnt ← 0.
  - else if cnt = DEBOUNCE_CYCLES-1: go to IDLE.
  - else cnt ← cnt+1.
- Encoding: bit n → 4'dn, for n = 0..9. Codes 10-15 are never produced.
- Reset mid-operation:
  - All state is cleared asynchronously and any pending digit is discarded.
  - After rst deasserts, a key still held is treated as a new press.

## Timing
- Reset values: digit_out=0, digit_valid=0, chord_err=0, busy=0. Internally key_s=0, cap=0, cnt=0.
- All outputs are registered.
- Latency: a key_in that is stable from edge 0 gives digit_valid=1 after edge DEBOUNCE_CYCLES+3 (2 sync + 1 IDLE + DEBOUNCE_CYCLES).
- The handshake transfers on the edge where digit_valid & digit_ready. digit_valid is 0 after that edge.
- digit_ready asserted before digit_valid gives the minimum EMIT dwell of 1 cycle.
- chord_err is high for exactly the cycle after the DEBOUNCE→RELEASE transition edge.
- Minimum spacing between two digits is 2·DEBOUNCE_CYCLES+4 cycles after the first press settles, with ready tied high.
- busy rises on the edge leaving IDLE and falls on the edge entering IDLE.

## Structure
- Package `decimal_pkg`:
  - `bcd_t` = logic [3:0].
  - keypad state enum (IDLE, DEBOUNCE, EMIT, RELEASE).
  - constant NUM_KEYS = 10.
  - function `is_onehot10`.
- Sub-module `dec_onehot_encode`: combinational; input 10-bit one-hot; outputs `bcd_t` digit and a `valid` flag (exactly one bit set). It is instantiated once on `cap`.
- The synchroniser, counter and FSM live in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 unless noted.
- Clean press of key 7 held for 20 cycles, ready=1 → digit_valid after edge 7; digit_out=4'd7; one transfer; busy returns low 4 cycles after release is synchronised.
- Key 3 bouncing (toggles every 2 cycles for 6 cycles, then stable) → exactly one digit 4'd3. A 3-cycle glitch on key 5 alone → no digit and no chord_err.
- Keys 2 and 9 pressed together, stable → chord_err pulses once, no digit_valid; a subsequent single press of 4 after full release gives 4'd4.
- Key 0 pressed with ready=0 for 10 cycles → digit_valid and digit_out=0 held for all 10 cycles; transfer on the first ready cycle; key released and re-pressed during the wait gives no extra digit.
- rst asserted during EMIT with key 6 held → outputs zero immediately; after deassert, key 6 is re-detected and emitted after 7 edges.
- Sweep keys 0-9 in turn with DEBOUNCE_CYCLES=2 → digit_out sequence 0..9, never a value >9.
